// File: rtl/dcache_meta_array_if.sv
// Meta-write, indexed-read and flush/init signals of the dcache metadata array.
// master: requester side, slave: the array.
interface dcache_meta_array_if #(
  parameter int unsigned N_SETS = 64,
  parameter int unsigned N_WAYS = 4,
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned COH_W  = 2
);
  localparam int unsigned IDX_W = $clog2(N_SETS);

  logic                      io_write_ready;
  logic                      io_write_valid;
  logic [IDX_W-1:0]          io_write_bits_idx;
  logic [N_WAYS-1:0]         io_write_bits_way_en;
  logic [TAG_W-1:0]          io_write_bits_tag;
  logic [COH_W-1:0]          io_write_bits_data_coh_state;
  logic [TAG_W-1:0]          io_write_bits_data_tag;

  logic                      io_read_ready;
  logic                      io_read_valid;
  logic [IDX_W-1:0]          io_read_bits_idx;

  logic                      io_resp_valid;
  logic [N_WAYS*COH_W-1:0]   io_resp_coh;
  logic [N_WAYS*TAG_W-1:0]   io_resp_tag;

  logic                      io_flush;
  logic                      io_init_done;

  modport master (
    input  io_write_ready,
    output io_write_valid, io_write_bits_idx, io_write_bits_way_en, io_write_bits_tag,
    output io_write_bits_data_coh_state, io_write_bits_data_tag,
    input  io_read_ready,
    output io_read_valid, io_read_bits_idx,
    input  io_resp_valid, io_resp_coh, io_resp_tag,
    output io_flush,
    input  io_init_done
  );

  modport slave (
    output io_write_ready,
    input  io_write_valid, io_write_bits_idx, io_write_bits_way_en, io_write_bits_tag,
    input  io_write_bits_data_coh_state, io_write_bits_data_tag,
    output io_read_ready,
    input  io_read_valid, io_read_bits_idx,
    output io_resp_valid, io_resp_coh, io_resp_tag,
    input  io_flush,
    output io_init_done
  );
endinterface

// File: rtl/dcache_meta_array.sv
// Dcache metadata array: per-set/per-way coh state and tag, one write and one read per cycle,
// invalidation sweep after reset and on flush. Optional macro META_BYPASS_EN forwards same-cycle writes to reads.
module dcache_meta_array #(
  parameter int unsigned N_SETS = 64,
  parameter int unsigned N_WAYS = 4,
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned COH_W  = 2
) (
  input  logic                clock,
  input  logic                reset,
  dcache_meta_array_if.slave  meta
);
  localparam int unsigned IDX_W = $clog2(N_SETS);
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(N_SETS - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic                     rdy_q;
  logic                     resp_valid_q;
  logic [N_WAYS*COH_W-1:0]  resp_coh_q;
  logic [N_WAYS*TAG_W-1:0]  resp_tag_q;

  logic [COH_W-1:0]         coh_q [N_SETS][N_WAYS];
  logic [TAG_W-1:0]         tag_q [N_SETS][N_WAYS];

  logic                     wr_fire_c;
  logic                     rd_fire_c;
  logic [N_WAYS*COH_W-1:0]  rd_coh_c;
  logic [N_WAYS*TAG_W-1:0]  rd_tag_c;
  logic                     unused_req_tag_c;

  assign wr_fire_c = meta.io_write_valid & rdy_q;
  assign rd_fire_c = meta.io_read_valid & rdy_q;

  // Request address tag travels with the write but is not part of the stored metadata.
  assign unused_req_tag_c = ^meta.io_write_bits_tag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == ST_IDLE);
    end
  end

  // Sweep sequencing and flush entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_SET) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (meta.io_flush) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage has no reset; the sweep is what clears it.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      for (int unsigned w = 0; w < N_WAYS; w++) begin
        coh_q[cnt_q][w] <= '0;
        tag_q[cnt_q][w] <= '0;
      end
    end else if (wr_fire_c) begin
      for (int unsigned w = 0; w < N_WAYS; w++) begin
        if (meta.io_write_bits_way_en[w]) begin
          coh_q[meta.io_write_bits_idx][w] <= meta.io_write_bits_data_coh_state;
          tag_q[meta.io_write_bits_idx][w] <= meta.io_write_bits_data_tag;
        end
      end
    end
  end

  // Read data for the requested set, optionally forwarding a same-cycle write.
  always_comb begin
    rd_coh_c = '0;
    rd_tag_c = '0;
    for (int unsigned w = 0; w < N_WAYS; w++) begin
      rd_coh_c[w*COH_W +: COH_W] = coh_q[meta.io_read_bits_idx][w];
      rd_tag_c[w*TAG_W +: TAG_W] = tag_q[meta.io_read_bits_idx][w];
`ifdef META_BYPASS_EN
      if (wr_fire_c && (meta.io_write_bits_idx == meta.io_read_bits_idx) &&
          meta.io_write_bits_way_en[w]) begin
        rd_coh_c[w*COH_W +: COH_W] = meta.io_write_bits_data_coh_state;
        rd_tag_c[w*TAG_W +: TAG_W] = meta.io_write_bits_data_tag;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_coh_q   <= '0;
      resp_tag_q   <= '0;
    end else begin
      resp_valid_q <= rd_fire_c;
      if (rd_fire_c) begin
        resp_coh_q <= rd_coh_c;
        resp_tag_q <= rd_tag_c;
      end
    end
  end

  assign meta.io_write_ready = rdy_q;
  assign meta.io_read_ready  = rdy_q;
  assign meta.io_init_done   = rdy_q;
  assign meta.io_resp_valid  = resp_valid_q;
  assign meta.io_resp_coh    = resp_coh_q;
  assign meta.io_resp_tag    = resp_tag_q;
endmodule

// File: tb/tb_dcache_meta_array.sv
// Scoreboard bench for dcache_meta_array: a set/way array model predicts read responses,
// a monitor pops and compares them on every response cycle.
module tb_dcache_meta_array;
  localparam int unsigned N_SETS = 64;
  localparam int unsigned N_WAYS = 4;
  localparam int unsigned TAG_W  = 20;
  localparam int unsigned COH_W  = 2;

  typedef struct packed {
    logic [N_WAYS*COH_W-1:0] coh;
    logic [N_WAYS*TAG_W-1:0] tag;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_meta_array_if #(.N_SETS(N_SETS), .N_WAYS(N_WAYS), .TAG_W(TAG_W), .COH_W(COH_W)) bus ();

  dcache_meta_array #(.N_SETS(N_SETS), .N_WAYS(N_WAYS), .TAG_W(TAG_W), .COH_W(COH_W)) dut (
    .clock (clk),
    .reset (rst_n),
    .meta  (bus)
  );

  int checks = 0;
  int failures = 0;
  int init_left = N_SETS;
  resp_t exp_q[$];
  resp_t mon_e;
  logic  mon_have;

  logic [COH_W-1:0] m_coh [N_SETS][N_WAYS];
  logic [TAG_W-1:0] m_tag [N_SETS][N_WAYS];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < N_SETS; s++)
      for (int w = 0; w < N_WAYS; w++) begin
        m_coh[s][w] = '0;
        m_tag[s][w] = '0;
      end
  endfunction

  function automatic resp_t model_read(input int idx);
    resp_t r;
    r = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      r.coh[w*COH_W +: COH_W] = m_coh[idx][w];
      r.tag[w*TAG_W +: TAG_W] = m_tag[idx][w];
    end
    return r;
  endfunction

  function automatic void model_write(input int idx, input logic [3:0] way, input logic [1:0] coh,
                                      input logic [19:0] tag);
    for (int w = 0; w < N_WAYS; w++)
      if (way[w]) begin
        m_coh[idx][w] = coh;
        m_tag[idx][w] = tag;
      end
  endfunction

  // Monitor: exactly one response per accepted read, on the following cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_have = (exp_q.size() > 0);
      check("resp_valid", 80'(bus.io_resp_valid), 80'(mon_have));
      if (mon_have) begin
        mon_e = exp_q.pop_front();
        if (bus.io_resp_valid) begin
          check("resp_coh", 80'(bus.io_resp_coh), 80'(mon_e.coh));
          check("resp_tag", 80'(bus.io_resp_tag), 80'(mon_e.tag));
        end
      end
    end
  end

  // One clock: check readiness, then apply the handshake to the model at the edge.
  task automatic step();
    @(negedge clk);
    if (rst_n) begin
      check("write_ready", 80'(bus.io_write_ready), 80'(init_left == 0));
      check("read_ready",  80'(bus.io_read_ready),  80'(init_left == 0));
      check("init_done",   80'(bus.io_init_done),   80'(init_left == 0));
    end
    @(posedge clk);
    if (rst_n) begin
      if (init_left == 0) begin
`ifdef META_BYPASS_EN
        if (bus.io_write_valid)
          model_write(int'(bus.io_write_bits_idx), bus.io_write_bits_way_en,
                      bus.io_write_bits_data_coh_state, bus.io_write_bits_data_tag);
        if (bus.io_read_valid) exp_q.push_back(model_read(int'(bus.io_read_bits_idx)));
`else
        if (bus.io_read_valid) exp_q.push_back(model_read(int'(bus.io_read_bits_idx)));
        if (bus.io_write_valid)
          model_write(int'(bus.io_write_bits_idx), bus.io_write_bits_way_en,
                      bus.io_write_bits_data_coh_state, bus.io_write_bits_data_tag);
`endif
        if (bus.io_flush) begin
          model_clear();
          init_left = N_SETS;
        end
      end else begin
        init_left--;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    init_left = N_SETS;
    repeat (hold) begin
      @(negedge clk);
      check("rst_write_ready", 80'(bus.io_write_ready), 80'(0));
      check("rst_read_ready",  80'(bus.io_read_ready),  80'(0));
      check("rst_resp_valid",  80'(bus.io_resp_valid),  80'(0));
      check("rst_resp_coh",    80'(bus.io_resp_coh),    80'(0));
      check("rst_resp_tag",    80'(bus.io_resp_tag),    80'(0));
      check("rst_init_done",   80'(bus.io_init_done),   80'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle();
    bus.io_write_valid = 1'b0;
    bus.io_read_valid  = 1'b0;
    bus.io_flush       = 1'b0;
  endtask

  task automatic set_wr(input int idx, input logic [3:0] way, input logic [1:0] coh, input logic [19:0] tag);
    bus.io_write_valid               = 1'b1;
    bus.io_write_bits_idx            = 6'(idx);
    bus.io_write_bits_way_en         = way;
    bus.io_write_bits_tag            = 20'($urandom());
    bus.io_write_bits_data_coh_state = coh;
    bus.io_write_bits_data_tag       = tag;
  endtask

  task automatic set_rd(input int idx);
    bus.io_read_valid    = 1'b1;
    bus.io_read_bits_idx = 6'(idx);
  endtask

  initial begin
    idle();
    bus.io_write_bits_idx            = '0;
    bus.io_write_bits_way_en         = '0;
    bus.io_write_bits_tag            = '0;
    bus.io_write_bits_data_coh_state = '0;
    bus.io_write_bits_data_tag       = '0;
    bus.io_read_bits_idx             = '0;

    // Reset, then sweep with a read held pending; first read of idx 5 sees zeros.
    do_reset(2);
    set_rd(5);
    repeat (N_SETS) step();
    step();
    idle();
    step();

    // Single-way write then read back.
    set_wr(3, 4'b0100, 2'd2, 20'hABCDE);
    step();
    idle();
    set_rd(3);
    step();
    idle();
    step();

    // Full-set write with concurrent read of the same set, then a follow-up read.
    set_wr(7, 4'b1111, 2'd3, 20'h12345);
    set_rd(7);
    step();
    idle();
    set_rd(7);
    step();
    idle();
    step();

    // way_en=0 write leaves a populated set untouched.
    set_wr(9, 4'b1111, 2'd1, 20'h0F0F0);
    step();
    set_wr(9, 4'b0000, 2'd3, 20'hFFFFF);
    step();
    idle();
    set_rd(9);
    step();
    idle();
    step();

    // Flush from IDLE with a same-cycle read and write; reads after the sweep see zeros.
    set_wr(1, 4'b1011, 2'd2, 20'h55AA5);
    step();
    idle();
    set_wr(2, 4'b0001, 2'd1, 20'h00777);
    set_rd(1);
    bus.io_flush = 1'b1;
    step();
    idle();
    set_rd(1);
    repeat (N_SETS + 2) step();
    idle();
    step();

    // Reset in the middle of a sweep restarts it from set 0.
    do_reset(1);
    set_rd(4);
    repeat (30) step();
    do_reset(1);
    repeat (N_SETS + 2) step();
    idle();
    step();

    // Randomized traffic, with collisions biased onto a few sets and rare flushes.
    for (int i = 0; i < 900; i++) begin
      bus.io_write_valid               = 1'($urandom_range(0, 1));
      bus.io_write_bits_idx            = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                                     : 6'($urandom_range(0, 3));
      bus.io_write_bits_way_en         = 4'($urandom_range(0, 15));
      bus.io_write_bits_tag            = 20'($urandom());
      bus.io_write_bits_data_coh_state = 2'($urandom_range(0, 3));
      bus.io_write_bits_data_tag       = 20'($urandom());
      bus.io_read_valid                = 1'($urandom_range(0, 1));
      bus.io_read_bits_idx             = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                                     : 6'($urandom_range(0, 3));
      bus.io_flush                     = ($urandom_range(0, 299) == 0);
      step();
    end
    idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_meta_array.md
Name: dcache_meta_array

Overview:
- Storage end of the dcache metadata write path.
- Sinks the single arbitrated meta-write stream (idx, way_en, tag, coh_state, stored tag) and holds per-set, per-way coherence state and tag.
- Serves one indexed read per cycle with 1-cycle latency to the tag-check stage.
- After reset, and on flush, runs an invalidation sweep before accepting traffic.

Parameters:
- N_SETS, 64, number of sets; idx width is log2(N_SETS).
- N_WAYS, 4, number of ways; width of way_en.
- TAG_W, 20, stored tag width.
- COH_W, 2, coherence state width; value 0 = invalid.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_write_ready  out  1  write accepted this cycle.
- io_write_valid  in  1  write request present.
- io_write_bits_idx  in  6  target set.
- io_write_bits_way_en  in  4  one-hot (or multi-hot) ways to update.
- io_write_bits_tag  in  20  request address tag; carried on the interface, not stored.
- io_write_bits_data_coh_state  in  2  coherence state to store.
- io_write_bits_data_tag  in  20  tag to store.
- io_read_ready  out  1  read accepted this cycle.
- io_read_valid  in  1  read request present.
- io_read_bits_idx  in  6  set to read.
- io_resp_valid  out  1  read data valid (one-cycle pulse).
- io_resp_coh  out  8  coh_state for way w at bits [2w+1:2w].
- io_resp_tag  out  80  tag for way w at bits [20w+19:20w].
- io_flush  in  1  request full invalidation sweep.
- io_init_done  out  1  high when in IDLE.

Behaviour:
- Storage is flops (N_SETS x N_WAYS x (COH_W+TAG_W)); it is not reset directly but is cleared by the sweep.
- Reset (reset=0) forces:
  - io_write_ready=0, io_read_ready=0, io_resp_valid=0.
  - io_resp_coh=0, io_resp_tag=0, io_init_done=0.
  - FSM to INIT, sweep counter to 0.
- FSM states: INIT, IDLE.
- INIT:
  - Each cycle writes coh=0, tag=0 to all ways of set[cnt], then cnt++.
  - Both readies are 0.
  - When cnt==N_SETS-1 is written, go to IDLE next cycle. The sweep takes exactly N_SETS cycles after reset release.
  - io_flush is ignored in INIT.
- IDLE:
  - io_write_ready=1, io_read_ready=1, io_init_done=1.
  - io_flush=1 → next cycle INIT with cnt=0; readies drop that next cycle.
  - A write or read handshaking in the same cycle as flush is still performed.
- Write (valid&ready):
  - At the clock edge, for every way w with way_en[w]=1, store {coh_state, data_tag} in set idx.
  - way_en=0 completes the handshake with no update.
- Read (valid&ready):
  - io_resp_valid=1 on the next cycle, with all ways of set idx latched as sampled at the handshake edge.
  - io_resp_coh and io_resp_tag hold their last values until the next read response.
  - io_resp_valid=0 in every cycle that does not follow a read handshake.
- Write and read in the same cycle are both accepted. Same-idx collision behaviour is set by META_BYPASS_EN.
- Async reset mid-sweep or mid-read:
  - Pending response is dropped (resp_valid=0).
  - Sweep restarts from set 0 after reset release.
- Index wrap: idx is exactly log2(N_SETS) bits; there is no out-of-range case.

Optional Feature:
- META_BYPASS_EN defined:
  - On a same-cycle write and read to the same idx, the response for ways with way_en[w]=1 returns the newly written coh/tag.
  - Other ways return the stored values.
- Not defined:
  - The response returns the pre-write contents for all ways (read-before-write).
  - The written values are visible to reads issued from the following cycle on.

Test Plan:
- Release reset, hold io_read_valid=1 → readies stay 0 for exactly 64 cycles, io_init_done rises on cycle 64, and the first read of idx 5 returns coh=0x00, tag=0.
- Write idx=3, way_en=4'b0100, coh=2, data_tag=0xABCDE; then read idx 3 → resp next cycle, coh=8'b00_10_00_00, tag bits[59:40]=0xABCDE, other ways 0.
- Write idx=7, way_en=4'b1111, coh=3, tag=0x12345, with a concurrent read of idx 7:
  - With META_BYPASS_EN: resp coh=0xFF, all tags 0x12345.
  - Without it: all zero; a read the next cycle returns 0xFF.
- Write way_en=0 to idx 9 after populating it → handshake completes, and a subsequent read shows the contents unchanged.
- Populate idx 1, pulse io_flush in IDLE → readies low for 64 cycles, then a read of idx 1 returns coh=0, tag=0.
- Assert reset at sweep cycle 30, release → a full 64-cycle sweep runs again, and io_resp_valid stays 0 throughout.
